// File: rtl/dht11_sample_scheduler.sv
// DHT11 measurement sequencer: timed/forced read starts with a minimum re-trigger gap,
// per-transaction timeout, checksum verification, bounded retries and published status.
module dht11_sample_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 3000,
  parameter int MIN_GAP_MS = 2000,
  parameter int TIMEOUT_MS = 10,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        force_req,
  output logic        rd_start,
  input  logic        rd_done,
  input  logic        rd_err,
  input  logic [39:0] rd_data,
  output logic [7:0]  humidity,
  output logic [7:0]  temperature,
  output logic        data_valid,
  output logic        sample_stb,
  output logic        sensor_fault,
  output logic [7:0]  err_cnt,
  output logic [5:0]  state_dbg
);

  localparam int TICK_DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_W     = 16;
  localparam int RW       = $clog2(MAX_RETRY + 1);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_WAIT  = 6'b000010,
    S_START = 6'b000100,
    S_BUSY  = 6'b001000,
    S_CHECK = 6'b010000,
    S_RETRY = 6'b100000
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_presc;
  logic [MS_W-1:0] r_ms_cnt;
  logic [RW-1:0]   r_retry_cnt;
  logic [39:0]     r_shadow;
  logic            r_force_pend;
  logic            r_rd_start;
  logic            r_sample_stb;
  logic            r_data_valid;
  logic            r_sensor_fault;
  logic [7:0]      r_humidity;
  logic [7:0]      r_temperature;
  logic [7:0]      r_err_cnt;

  logic w_tick, w_period_hit, w_gap_hit, w_timeout_hit, w_retry_left, w_frame_ok;
  logic w_state_chg, w_pass, w_round_fail, w_enter_retry, w_enter_start, w_capture;

  // Byte sum of the first four bytes must match the checksum; an all-zero frame is rejected.
  function automatic logic f_frame_ok(input logic [39:0] frame);
    logic [7:0] sum;
    sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return (sum == frame[7:0]) && (frame != 40'd0);
  endfunction

  assign w_tick        = (r_presc == PW'(TICK_DIV - 1));
  assign w_period_hit  = (r_ms_cnt >= MS_W'(PERIOD_MS));
  assign w_gap_hit     = (r_ms_cnt >= MS_W'(MIN_GAP_MS));
  assign w_timeout_hit = (r_ms_cnt >= MS_W'(TIMEOUT_MS));
  assign w_retry_left  = (r_retry_cnt < RW'(MAX_RETRY));
  assign w_frame_ok    = f_frame_ok(r_shadow);

  assign w_state_chg   = (w_next != r_state);
  assign w_pass        = (r_state == S_CHECK) && (w_next == S_WAIT);
  assign w_round_fail  = (r_state == S_RETRY) && (w_next == S_WAIT);
  assign w_enter_retry = w_state_chg && (w_next == S_RETRY);
  assign w_enter_start = w_state_chg && (w_next == S_START);
  assign w_capture     = (r_state == S_BUSY) && (w_next == S_CHECK);

  // Next-state selection; enable low overrides every state.
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next = S_WAIT;
        S_WAIT: begin
          if (w_period_hit || (r_force_pend && w_gap_hit)) w_next = S_START;
          else                                             w_next = S_WAIT;
        end
        S_START: w_next = S_BUSY;
        S_BUSY: begin
          if (rd_err)             w_next = S_RETRY;
          else if (rd_done)       w_next = S_CHECK;
          else if (w_timeout_hit) w_next = S_RETRY;
          else                    w_next = S_BUSY;
        end
        S_CHECK: begin
          if (w_frame_ok) w_next = S_WAIT;
          else            w_next = S_RETRY;
        end
        S_RETRY: begin
          if (!w_retry_left)  w_next = S_WAIT;
          else if (w_gap_hit) w_next = S_START;
          else                w_next = S_RETRY;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register and millisecond timebase; both timers restart on every state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_presc  <= {PW{1'b0}};
      r_ms_cnt <= {MS_W{1'b0}};
    end else begin
      r_state <= w_next;
      if (w_state_chg) begin
        r_presc  <= {PW{1'b0}};
        r_ms_cnt <= {MS_W{1'b0}};
      end else if (w_tick) begin
        r_presc <= {PW{1'b0}};
        if (r_ms_cnt != {MS_W{1'b1}}) r_ms_cnt <= r_ms_cnt + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Strobes, retry bookkeeping and the published sample/status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_start     <= 1'b0;
      r_sample_stb   <= 1'b0;
      r_force_pend   <= 1'b0;
      r_shadow       <= 40'd0;
      r_retry_cnt    <= {RW{1'b0}};
      r_err_cnt      <= 8'd0;
      r_humidity     <= 8'd0;
      r_temperature  <= 8'd0;
      r_data_valid   <= 1'b0;
      r_sensor_fault <= 1'b0;
    end else begin
      r_rd_start   <= w_enter_start;
      r_sample_stb <= w_pass;
      // A request arriving on the same edge as a start survives for the next window.
      if (force_req && (r_state != S_IDLE)) r_force_pend <= 1'b1;
      else if (w_enter_start)               r_force_pend <= 1'b0;
      if (w_capture) r_shadow <= rd_data;
      if (w_pass || w_round_fail) r_retry_cnt <= {RW{1'b0}};
      else if (w_enter_retry)     r_retry_cnt <= r_retry_cnt + 1'b1;
      if (w_enter_retry && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_pass) begin
        r_humidity     <= r_shadow[39:32];
        r_temperature  <= r_shadow[23:16];
        r_data_valid   <= 1'b1;
        r_sensor_fault <= 1'b0;
      end else if (w_round_fail) begin
        r_data_valid   <= 1'b0;
        r_sensor_fault <= 1'b1;
      end
    end
  end

  assign rd_start     = r_rd_start;
  assign sample_stb   = r_sample_stb;
  assign humidity     = r_humidity;
  assign temperature  = r_temperature;
  assign data_valid   = r_data_valid;
  assign sensor_fault = r_sensor_fault;
  assign err_cnt      = r_err_cnt;
  assign state_dbg    = r_state;

endmodule
